thunderbird_taillight_ctrl: RTL and testbench



---
 rtl/thunderbird_taillight_ctrl.sv | 104 ++++++++++
 tb/tb_thunderbird_taillight_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/thunderbird_taillight_ctrl.sv
// Thunderbird tail-light sequencer: 2-flop input synchronizers, tick divider, Moore FSM, registered lamps.
// Optional debug outputs on io_out[7:6] when THUNDERBIRD_DBG_EN is defined.
module thunderbird_taillight_ctrl #(
    parameter int MAX_COUNT   = 1000,
    parameter int SYSTEM_FREQ = 6250,
    parameter int HZ          = 8
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);
    localparam int DIV   = SYSTEM_FREQ / HZ;
    localparam int CNT_W = $clog2(MAX_COUNT);

    typedef enum logic [2:0] {
        S_IDLE, S_L1, S_L2, S_L3, S_R1, S_R2, S_R3, S_LR3
    } state_t;

    logic w_clk, w_rst_n, w_unused;
    assign w_clk    = io_in[0];
    assign w_rst_n  = io_in[1];
    assign w_unused = ^io_in[7:5];

    // Switch order in the synchronizer: {haz, right, left}
    logic [2:0]       r_sync1, r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             w_tick;
    state_t           r_state, w_next;
    logic [5:0]       r_lamps, w_lamps;
    logic             w_left, w_right, w_haz;

    assign w_left  = r_sync2[0];
    assign w_right = r_sync2[1];
    assign w_haz   = r_sync2[2];
    assign w_tick  = (r_cnt == CNT_W'(DIV - 1));

    // NOTE: reset is sampled on the clock edge, so it sits inside the clocked branch, and all state uses <=.
    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= io_in[4:2];
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge w_clk) begin
        if (!w_rst_n || w_tick) r_cnt <= '0;
        else                    r_cnt <= r_cnt + 1'b1;
    end

    always_ff @(posedge w_clk) begin
        if (!w_rst_n)    r_state <= S_IDLE;
        else if (w_tick) r_state <= w_next;
    end

    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    always_comb begin
        w_next  = r_state;
        w_lamps = 6'b000000;
        unique case (r_state)
            S_IDLE: begin
                if (w_haz || (w_left && w_right)) w_next = S_LR3;
                else if (w_left)                  w_next = S_L1;
                else if (w_right)                 w_next = S_R1;
            end
            S_L1: begin w_next = w_haz ? S_LR3 : S_L2; w_lamps = 6'b001000; end
            S_L2: begin w_next = w_haz ? S_LR3 : S_L3; w_lamps = 6'b011000; end
            S_L3: begin w_next = S_IDLE;               w_lamps = 6'b111000; end
            S_R1: begin w_next = w_haz ? S_LR3 : S_R2; w_lamps = 6'b000100; end
            S_R2: begin w_next = w_haz ? S_LR3 : S_R3; w_lamps = 6'b000110; end
            S_R3: begin w_next = S_IDLE;               w_lamps = 6'b000111; end
            S_LR3: begin w_next = S_IDLE;              w_lamps = 6'b111111; end
            default: w_next = S_IDLE;
        endcase
    end

    // Lamps follow the state one cycle later, free of input-driven glitches.
    always_ff @(posedge w_clk) begin
        if (!w_rst_n) r_lamps <= '0;
        else          r_lamps <= w_lamps;
    end

    assign io_out[5:0] = r_lamps;

`ifdef THUNDERBIRD_DBG_EN
    logic r_dbg_tick, r_dbg_lr3;

    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            r_dbg_tick <= 1'b0;
            r_dbg_lr3  <= 1'b0;
        end else begin
            r_dbg_tick <= w_tick;
            r_dbg_lr3  <= (r_state == S_LR3);
        end
    end

    assign io_out[7:6] = {r_dbg_lr3, r_dbg_tick};
`else
    assign io_out[7:6] = 2'b00;
`endif

endmodule

// File: tb/tb_thunderbird_taillight_ctrl.sv
// Directed bench for thunderbird_taillight_ctrl with default parameters (DIV = 781).
module tb_thunderbird_taillight_ctrl;
    localparam int DIV = 781;

    logic       clk = 1'b0;
    logic       rst_n, left, right, haz;
    logic [7:0] io_in, io_out;
    int         n_vec = 0;
    int         n_err = 0;

    assign io_in = {3'b000, haz, right, left, rst_n, clk};

    thunderbird_taillight_ctrl dut (
        .io_in  (io_in),
        .io_out (io_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at the first cycle a pattern is visible: checks entry and last cycle, ends at next entry.
    task automatic hold(input string tag, input logic [5:0] pat);
        check({tag, "_entry"}, {2'b00, io_out[5:0]}, {2'b00, pat});
        step(DIV - 1);
        check({tag, "_last"}, {2'b00, io_out[5:0]}, {2'b00, pat});
        step(1);
    endtask

    // One-cycle reset pulse; lamps stay dark until the first tick, ends at first post-tick cycle.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        step(1);
        check({tag, "_rst"}, io_out, 8'h00);
        rst_n = 1'b1;
        step(DIV);
        check({tag, "_pre_tick"}, {2'b00, io_out[5:0]}, 8'h00);
        step(1);
    endtask

    initial begin
        rst_n = 1'b0; left = 1'b0; right = 1'b0; haz = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("rst_hold", io_out, 8'h00);
        end

        // Left held from release
        haz = 1'b0; left = 1'b1;
        rst_n = 1'b1;
        step(DIV);
        check("left_pre_tick", {2'b00, io_out[5:0]}, 8'h00);
        step(1);
        hold("left_L1", 6'b001000);
        hold("left_L2", 6'b011000);
        hold("left_L3", 6'b111000);
        hold("left_idle", 6'b000000);
        hold("left_L1b", 6'b001000);
`ifndef THUNDERBIRD_DBG_EN
        check("dbg_bits_zero", {6'b0, io_out[7:6]}, 8'h00);
`endif

        // Right held
        left = 1'b0; right = 1'b1;
        do_reset("right");
        hold("right_R1", 6'b000100);
        hold("right_R2", 6'b000110);
        hold("right_R3", 6'b000111);
        hold("right_idle", 6'b000000);
        hold("right_R1b", 6'b000100);

        // Hazard held
        right = 1'b0; haz = 1'b1;
        do_reset("haz");
        hold("haz_on", 6'b111111);
        hold("haz_off", 6'b000000);
        hold("haz_on2", 6'b111111);

        // Both turn switches act as hazard
        haz = 1'b0; left = 1'b1; right = 1'b1;
        do_reset("lr");
        hold("lr_on", 6'b111111);
        hold("lr_off", 6'b000000);
        hold("lr_on2", 6'b111111);

        // Left into L2, then hazard overrides
        right = 1'b0;
        do_reset("ovr");
        hold("ovr_L1", 6'b001000);
        left = 1'b0; haz = 1'b1;
        hold("ovr_L2", 6'b011000);
        hold("ovr_LR3", 6'b111111);
        hold("ovr_idle", 6'b000000);
        haz = 1'b0;

        // Short pulse between ticks is ignored
        do_reset("pulse");
        step(300);
        left = 1'b1;
        step(5);
        left = 1'b0;
        step(DIV - 306);
        check("pulse_tick_edge", {2'b00, io_out[5:0]}, 8'h00);
        step(1);
        hold("pulse_idle", 6'b000000);

        // Reset mid-R3 with right still held
        right = 1'b1;
        do_reset("r3pre");
        hold("r3_R1", 6'b000100);
        hold("r3_R2", 6'b000110);
        check("r3_R3", {2'b00, io_out[5:0]}, 8'b00000111);
        step(100);
        do_reset("r3");
        hold("r3_R1_again", 6'b000100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
